// File: rtl/panel_layer_compositor.sv
// Panel layer compositor: walks every pixel index, requests one pixel from the
// attached layer source, and read-modify-writes the blended result into the
// frame buffer. One pass composites one layer.
module panel_layer_compositor #(
    parameter int PIXELS  = 1024,
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [7:0]  timeout_count,
    output logic        layer_valid,
    output logic [9:0]  layer_index,
    input  logic        layer_ready,
    input  logic [7:0]  layer_red,
    input  logic [7:0]  layer_green,
    input  logic [7:0]  layer_blue,
    input  logic [7:0]  layer_alpha,
    input  logic [1:0]  layer_blend,
    output logic [9:0]  fb_rd_addr,
    input  logic [23:0] fb_rd_data,
    output logic        fb_wr_en,
    output logic [9:0]  fb_wr_addr,
    output logic [23:0] fb_wr_data
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_REQ   = 2'd1;
    localparam logic [1:0] S_BLEND = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [9:0] LAST_IDX = 10'(PIXELS - 1);
    localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT);

    logic [1:0] state_q, state_d;
    logic [9:0] idx_q, idx_d;
    logic [7:0] wait_q, wait_d;
    logic [7:0] tcnt_q, tcnt_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       valid_q, valid_d;
    logic       wr_en_q, wr_en_d;
    logic [7:0] px_r_q, px_r_d;
    logic [7:0] px_g_q, px_g_d;
    logic [7:0] px_b_q, px_b_d;
    logic [7:0] px_a_q, px_a_d;
    logic [1:0] px_m_q, px_m_d;

    // Additive blend: 9-bit sum clamped to full scale.
    function automatic logic [7:0] sat_add(input logic [7:0] c, input logic [7:0] b);
        logic [8:0] sum;
        sum = {1'b0, c} + {1'b0, b};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

    // Alpha blend with +255 bias so a=255 yields c and a=0 yields b exactly.
    function automatic logic [7:0] alpha_mix(input logic [7:0] c, input logic [7:0] b,
                                             input logic [7:0] a);
        logic [15:0] sum;
        sum = ({8'd0, c} * {8'd0, a}) + ({8'd0, b} * {8'd0, 8'd255 - a}) + 16'd255;
        return 8'(sum >> 8);
    endfunction

    function automatic logic [7:0] blend_ch(input logic [1:0] mode, input logic [7:0] c,
                                            input logic [7:0] b, input logic [7:0] a);
        case (mode)
            2'd1:    return sat_add(c, b);
            2'd2:    return alpha_mix(c, b, a);
            default: return c;
        endcase
    endfunction

    // Next-state logic for the pixel walk and handshake.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        wait_d  = wait_q;
        tcnt_d  = tcnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        valid_d = valid_q;
        wr_en_d = 1'b0;
        px_r_d  = px_r_q;
        px_g_d  = px_g_q;
        px_b_d  = px_b_q;
        px_a_d  = px_a_q;
        px_m_d  = px_m_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_REQ;
                    idx_d   = 10'd0;
                    wait_d  = 8'd0;
                    tcnt_d  = 8'd0;
                    busy_d  = 1'b1;
                    valid_d = 1'b1;
                end
            end
            S_REQ: begin
                wait_d = wait_q + 8'd1;
                if (layer_ready) begin
                    px_r_d  = layer_red;
                    px_g_d  = layer_green;
                    px_b_d  = layer_blue;
                    px_a_d  = layer_alpha;
                    px_m_d  = layer_blend;
                    wr_en_d = (layer_blend != 2'd3);
                    valid_d = 1'b0;
                    state_d = S_BLEND;
                end else if (wait_q + 8'd1 == TO_LIMIT) begin
                    // Abandoned pixel: no write, just account for it.
                    if (tcnt_q != 8'hFF) begin
                        tcnt_d = tcnt_q + 8'd1;
                    end
                    valid_d = 1'b0;
                    state_d = S_BLEND;
                end
            end
            S_BLEND: begin
                if (idx_q == LAST_IDX) begin
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + 10'd1;
                    wait_d  = 8'd0;
                    valid_d = 1'b1;
                    state_d = S_REQ;
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and registered outputs, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= 10'd0;
            wait_q  <= 8'd0;
            tcnt_q  <= 8'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            wr_en_q <= 1'b0;
            px_r_q  <= 8'd0;
            px_g_q  <= 8'd0;
            px_b_q  <= 8'd0;
            px_a_q  <= 8'd0;
            px_m_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wait_q  <= wait_d;
            tcnt_q  <= tcnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            valid_q <= valid_d;
            wr_en_q <= wr_en_d;
            px_r_q  <= px_r_d;
            px_g_q  <= px_g_d;
            px_b_q  <= px_b_d;
            px_a_q  <= px_a_d;
            px_m_q  <= px_m_d;
        end
    end

    // The RAM read data arrives during BLEND; the blend of it with the captured
    // pixel is gated by the registered write strobe so nothing leaks out otherwise.
    assign fb_wr_data = wr_en_q ? {blend_ch(px_m_q, px_r_q, fb_rd_data[23:16], px_a_q),
                                   blend_ch(px_m_q, px_g_q, fb_rd_data[15:8],  px_a_q),
                                   blend_ch(px_m_q, px_b_q, fb_rd_data[7:0],   px_a_q)}
                                : 24'd0;

    assign busy          = busy_q;
    assign done          = done_q;
    assign timeout_count = tcnt_q;
    assign layer_valid   = valid_q;
    assign layer_index   = idx_q;
    assign fb_rd_addr    = idx_q;
    assign fb_wr_en      = wr_en_q;
    assign fb_wr_addr    = idx_q;

endmodule

// File: tb/tb_panel_layer_compositor.sv
// Directed bench for panel_layer_compositor: frame-buffer RAM model, a
// scriptable layer source, and a second instance that never gets ready.
module tb_panel_layer_compositor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start;
    logic        busy, done;
    logic [7:0]  timeout_count;
    logic        layer_valid;
    logic [9:0]  layer_index;
    logic        layer_ready;
    logic [7:0]  layer_red, layer_green, layer_blue, layer_alpha;
    logic [1:0]  layer_blend;
    logic [9:0]  fb_rd_addr;
    logic [23:0] fb_rd_data;
    logic        fb_wr_en;
    logic [9:0]  fb_wr_addr;
    logic [23:0] fb_wr_data;

    logic        t_start;
    logic        t_busy, t_done;
    logic [7:0]  t_timeout_count;
    logic        t_layer_valid;
    logic [9:0]  t_layer_index;
    logic [9:0]  t_fb_rd_addr;
    logic        t_fb_wr_en;
    logic [9:0]  t_fb_wr_addr;
    logic [23:0] t_fb_wr_data;

    panel_layer_compositor dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .timeout_count(timeout_count), .layer_valid(layer_valid), .layer_index(layer_index),
        .layer_ready(layer_ready), .layer_red(layer_red), .layer_green(layer_green),
        .layer_blue(layer_blue), .layer_alpha(layer_alpha), .layer_blend(layer_blend),
        .fb_rd_addr(fb_rd_addr), .fb_rd_data(fb_rd_data), .fb_wr_en(fb_wr_en),
        .fb_wr_addr(fb_wr_addr), .fb_wr_data(fb_wr_data)
    );

    panel_layer_compositor #(.PIXELS(8), .TIMEOUT(4)) dut_to (
        .clk(clk), .rst_n(rst_n), .start(t_start), .busy(t_busy), .done(t_done),
        .timeout_count(t_timeout_count), .layer_valid(t_layer_valid), .layer_index(t_layer_index),
        .layer_ready(1'b0), .layer_red(8'hAA), .layer_green(8'hBB),
        .layer_blue(8'hCC), .layer_alpha(8'hFF), .layer_blend(2'd0),
        .fb_rd_addr(t_fb_rd_addr), .fb_rd_data(24'h123456), .fb_wr_en(t_fb_wr_en),
        .fb_wr_addr(t_fb_wr_addr), .fb_wr_data(t_fb_wr_data)
    );

    function automatic logic [23:0] pat(input int i);
        return {8'(i), 8'(i >> 2) ^ 8'hA5, 8'(i * 3)};
    endfunction

    function automatic logic [23:0] bg_word(input logic [1:0] mode, input int k);
        if (mode == 2'd0) return 24'd0;
        if (k < 3) return 24'h646464;
        if (k < 5) return 24'h202020;
        return {8'(k), 8'h5A, 8'(k >> 2)};
    endfunction

    // Hand-computed results of the mixed-mode pass.
    function automatic logic [23:0] exp_b(input int k);
        case (k)
            0: return 24'hC8C8C8;   // alpha 255 -> layer colour
            1: return 24'h646464;   // alpha 0 -> background
            2: return 24'h969696;   // (200*128 + 100*127 + 255) >> 8 = 150
            3: return 24'hFFFFFF;   // 0xF0 + 0x20 saturates
            4: return 24'h303030;   // 0x10 + 0x20
            default: return (k % 2 == 1) ? (pat(k) ^ 24'h0F0F0F) : bg_word(2'd1, k);
        endcase
    endfunction

    // Frame-buffer RAM: synchronous 1-cycle read, bulk preload on request.
    logic [23:0] mem [1024];
    logic        fb_init = 1'b0;
    logic [1:0]  fb_mode = 2'd0;
    always @(posedge clk) begin
        if (fb_init) begin
            for (int k = 0; k < 1024; k++) mem[k] <= bg_word(fb_mode, k);
        end else if (fb_wr_en) begin
            mem[fb_wr_addr] <= fb_wr_data;
        end
        fb_rd_data <= mem[fb_rd_addr];
    end

    // Layer source: mode 0 zero-latency replace; mode 1 mixed blends with latency index%3.
    logic [1:0] src_mode = 2'd0;
    int         src_wait = 0;
    always @(posedge clk) begin
        if (!layer_valid || layer_ready) src_wait <= 0;
        else src_wait <= src_wait + 1;
    end

    always_comb begin
        layer_ready = 1'b0;
        {layer_red, layer_green, layer_blue} = 24'hDEADBE;
        layer_alpha = 8'h5C;
        layer_blend = 2'd2;
        if (src_mode == 2'd0) begin
            layer_ready = layer_valid;
            {layer_red, layer_green, layer_blue} = pat(int'(layer_index));
            layer_alpha = 8'h00;
            layer_blend = 2'd0;
        end else begin
            layer_ready = layer_valid && (src_wait >= (int'(layer_index) % 3));
            if (layer_ready) begin
                case (int'(layer_index))
                    0: begin {layer_red, layer_green, layer_blue} = 24'hC8C8C8; layer_alpha = 8'hFF; layer_blend = 2'd2; end
                    1: begin {layer_red, layer_green, layer_blue} = 24'hC8C8C8; layer_alpha = 8'h00; layer_blend = 2'd2; end
                    2: begin {layer_red, layer_green, layer_blue} = 24'hC8C8C8; layer_alpha = 8'h80; layer_blend = 2'd2; end
                    3: begin {layer_red, layer_green, layer_blue} = 24'hF0F0F0; layer_alpha = 8'h00; layer_blend = 2'd1; end
                    4: begin {layer_red, layer_green, layer_blue} = 24'h101010; layer_alpha = 8'h00; layer_blend = 2'd1; end
                    default: begin
                        if (layer_index[0]) begin
                            {layer_red, layer_green, layer_blue} = pat(int'(layer_index)) ^ 24'h0F0F0F;
                            layer_alpha = 8'h00;
                            layer_blend = 2'd0;
                        end else begin
                            {layer_red, layer_green, layer_blue} = 24'h010203;
                            layer_alpha = 8'hFF;
                            layer_blend = 2'd3;
                        end
                    end
                endcase
            end
        end
    end

    // Write monitors.
    int even_wr = 0;
    int t_wr_cnt = 0;
    always @(posedge clk) begin
        if (fb_wr_en && src_mode == 2'd1 && fb_wr_addr >= 10'd5 && !fb_wr_addr[0]) even_wr <= even_wr + 1;
        if (t_fb_wr_en) t_wr_cnt <= t_wr_cnt + 1;
    end

    int vecs = 0;
    int miss = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input bit sel, input int bound, output bit got);
        got = 1'b0;
        for (int n = 0; n < bound; n++) begin
            if ((sel ? t_done : done) === 1'b1) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        bit got;
        int cnt;
        rst_n   = 1'b0;
        start   = 1'b0;
        t_start = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_ctl",   64'({busy, done, layer_valid, fb_wr_en, timeout_count}), 64'd0);
        check("rst_addr",  64'({layer_index, fb_rd_addr, fb_wr_addr}), 64'd0);
        check("rst_wdata", 64'(fb_wr_data), 64'd0);
        check("rst_t_ctl", 64'({t_busy, t_done, t_layer_valid, t_fb_wr_en, t_timeout_count}), 64'd0);
        check("rst_t_dat", 64'({t_layer_index, t_fb_rd_addr, t_fb_wr_addr, t_fb_wr_data}), 64'd0);

        fb_mode = 2'd0; fb_init = 1'b1; @(negedge clk); fb_init = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_busy", 64'(busy), 64'd0);

        // Pass A: zero-latency replace, with a stray start mid-pass.
        src_mode = 2'd0;
        start = 1'b1; @(negedge clk); start = 1'b0;
        check("A_busy", 64'(busy), 64'd1);
        check("A_first_req", 64'({layer_valid, layer_index}), 64'({1'b1, 10'd0}));
        cnt = 1;   // this sample is the first REQ cycle
        got = 1'b0;
        for (int n = 0; n < 5000; n++) begin
            if (done === 1'b1) begin got = 1'b1; break; end
            start = (cnt == 100);
            @(negedge clk);
            cnt++;
        end
        start = 1'b0;
        check("A_done_seen", 64'(got), 64'd1);
        check("A_done_cycle", 64'(cnt), 64'd2049);
        check("A_tcnt", 64'(timeout_count), 64'd0);
        @(negedge clk);
        check("A_done_pulse", 64'({done, busy}), 64'd0);
        for (int k = 0; k < 1024; k++) check($sformatf("A_word%0d", k), 64'(mem[k]), 64'(pat(k)));

        // Pass B: alpha/add/transparent blends with variable ready latency.
        fb_mode = 2'd1; fb_init = 1'b1; @(negedge clk); fb_init = 1'b0;
        src_mode = 2'd1;
        start = 1'b1; @(negedge clk); start = 1'b0;
        wait_done(1'b0, 10000, got);
        check("B_done_seen", 64'(got), 64'd1);
        check("B_tcnt", 64'(timeout_count), 64'd0);
        check("B_even_writes", 64'(even_wr), 64'd0);
        @(negedge clk);
        for (int k = 0; k < 1024; k++) check($sformatf("B_word%0d", k), 64'(mem[k]), 64'(exp_b(k)));

        // Pass C: reset during the request for index 500, then a clean restart.
        fb_mode = 2'd0; fb_init = 1'b1; @(negedge clk); fb_init = 1'b0;
        src_mode = 2'd0;
        start = 1'b1; @(negedge clk); start = 1'b0;
        got = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            if (layer_valid === 1'b1 && layer_index === 10'd500) begin got = 1'b1; break; end
            @(negedge clk);
        end
        check("C_reach500", 64'(got), 64'd1);
        rst_n = 1'b0;
        #1;
        check("C_rst_ctl",   64'({busy, done, layer_valid, fb_wr_en, timeout_count}), 64'd0);
        check("C_rst_addr",  64'({layer_index, fb_rd_addr, fb_wr_addr}), 64'd0);
        check("C_rst_wdata", 64'(fb_wr_data), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("C_word500", 64'(mem[500]), 64'd0);
        check("C_word499", 64'(mem[499]), 64'(pat(499)));
        start = 1'b1; @(negedge clk); start = 1'b0;
        check("C_restart", 64'({busy, done, layer_valid, layer_index}), 64'({1'b1, 1'b0, 1'b1, 10'd0}));
        wait_done(1'b0, 5000, got);
        check("C_done_seen", 64'(got), 64'd1);
        @(negedge clk);
        check("C_done_pulse", 64'({done, busy}), 64'd0);
        check("C_word1023", 64'(mem[1023]), 64'(pat(1023)));

        // Pass D: source never ready, TIMEOUT=4, PIXELS=8.
        t_start = 1'b1; @(negedge clk); t_start = 1'b0;
        check("D_busy", 64'(t_busy), 64'd1);
        wait_done(1'b1, 200, got);
        check("D_done_seen", 64'(got), 64'd1);
        check("D_tcnt", 64'(t_timeout_count), 64'd8);
        check("D_writes", 64'(t_wr_cnt), 64'd0);
        @(negedge clk);
        check("D_done_pulse", 64'({t_done, t_busy}), 64'd0);
        repeat (3) @(negedge clk);
        check("D_tcnt_hold", 64'(t_timeout_count), 64'd8);
        t_start = 1'b1; @(negedge clk); t_start = 1'b0;
        check("D_tcnt_clear", 64'(t_timeout_count), 64'd0);
        wait_done(1'b1, 200, got);
        check("D2_done_seen", 64'(got), 64'd1);
        check("D2_tcnt", 64'(t_timeout_count), 64'd8);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule
